// File: rtl/hit_judge.sv
// Whack-a-mole hit judge: strike edges, BCD score, lives and game over.
// One strike per cooldown window; fail edges cost lives until OVER.
module hit_judge #(
    parameter int unsigned COOLDOWN = 4,
    parameter int unsigned LIVES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] mole,
    input  logic [9:0] fail,
    input  logic [9:0] sw,
    output logic [9:0] hit_clr,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    typedef enum logic [1:0] {PLAY, COOL, OVER} state_t;

    state_t     state, state_n;
    logic [9:0] sw_q, fail_q;
    logic [9:0] se, fe, hit_mask, hit_n, fe_cost;
    logic [7:0] cnt, cnt_n, score_n;
    logic [1:0] lives_n;
    logic [3:0] cost;
    logic       one_hot, many, go_n;

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)
            return s;
        if (s[3:0] == 4'd9)
            return {s[7:4] + 4'd1, 4'd0};
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] s);
        if (s == 8'h00)
            return s;
        if (s[3:0] == 4'd0)
            return {s[7:4] - 4'd1, 4'd9};
        return {s[7:4], s[3:0] - 4'd1};
    endfunction

    // Edge detection, strike classification and the life cost of fail edges
    always_comb begin
        se       = sw & ~sw_q;
        fe       = fail & ~fail_q;
        one_hot  = (se != 10'd0) && ((se & (se - 10'd1)) == 10'd0);
        many     = (se != 10'd0) && !one_hot;
        hit_mask = (state == PLAY && one_hot) ? (se & mole) : 10'd0;
        fe_cost  = fe & ~hit_mask;
        cost     = 4'd0;
        for (int i = 0; i < 10; i++)
            cost = cost + {3'd0, fe_cost[i]};
    end

    // Next-state, score, lives and registered-output values
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        score_n = score;
        lives_n = lives;
        hit_n   = 10'd0;
        unique case (state)
            PLAY: begin
                if (one_hot) begin
                    state_n = COOL;
                    cnt_n   = 8'(COOLDOWN - 1);
                    if (hit_mask != 10'd0) begin
                        hit_n   = hit_mask;
                        score_n = bcd_inc(score);
                    end else begin
                        score_n = bcd_dec(score);
                    end
                end else if (many) begin
                    state_n = COOL;
                    cnt_n   = 8'(COOLDOWN - 1);
                end
            end
            COOL: begin
                if (cnt == 8'd0)
                    state_n = PLAY;
                else
                    cnt_n = cnt - 8'd1;
            end
            OVER: begin
                hit_n = 10'h3FF;
            end
            default: state_n = PLAY;
        endcase
        if (state != OVER && cost != 4'd0) begin
            if (cost >= {2'b00, lives}) begin
                lives_n = 2'd0;
                state_n = OVER;
            end else begin
                lives_n = lives - cost[1:0];
            end
        end
        if (state_n == OVER)
            hit_n = 10'h3FF;
        go_n = (state_n == OVER);
    end

    // State and output registers; input history tracks levels even in reset
    always_ff @(posedge clk) begin
        sw_q   <= sw;
        fail_q <= fail;
        if (rst) begin
            state     <= PLAY;
            cnt       <= 8'd0;
            score     <= 8'h00;
            lives     <= 2'(LIVES);
            hit_clr   <= 10'd0;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            score     <= score_n;
            lives     <= lives_n;
            hit_clr   <= hit_n;
            game_over <= go_n;
        end
    end

endmodule
